// File: rtl/lif_pkg.sv
// Shared definitions for the spike decoding blocks: FSM state type,
// default widths and a saturating-increment helper.
// Optional build macro used by spike_rate_decoder: SPIKE_DECODE_SMOOTH_EN.
package lif_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } lif_state_e;

   localparam int unsigned LIF_WIN_LOG2 = 8;
   localparam int unsigned LIF_CNT_W    = 8;
   localparam int unsigned LIF_ISI_W    = 8;

   // Increment val_i by one when inc_i is set, clamping at max_i.
   // Operands are zero-extended to 32 bits by the caller and the result
   // is cast back down to the counter width at the call site.
   function automatic logic [31:0] sat_inc(input logic [31:0] val_i,
                                           input logic [31:0] max_i,
                                           input logic        inc_i);
      logic [31:0] res;
      if (!inc_i) begin
         res = val_i;
      end else if (val_i >= max_i) begin
         res = max_i;
      end else begin
         res = val_i + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/spike_isi_meter.sv
// Inter-spike interval meter: measures cycles between consecutive spike
// edges while the decoder is active. The first edge after activation only
// arms the meter; every later edge reports the saturated interval.
module spike_isi_meter
   import lif_pkg::*;
#(
   parameter int unsigned ISI_W = LIF_ISI_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             edge_i,
   input  logic             active_i,
   output logic [ISI_W-1:0] isi_o,
   output logic             isi_valid_o
);

   localparam logic [31:0] ISI_MAX = 32'((64'd1 << ISI_W) - 64'd1);

   logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
   logic             seen_q, seen_d;
   logic [ISI_W-1:0] isi_q, isi_d;
   logic             isi_valid_q, isi_valid_d;
   logic [ISI_W-1:0] isi_inc;

   // Next-state computation for interval counter, arm flag and reported value.
   always_comb begin
      isi_inc     = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_MAX, 1'b1));
      isi_cnt_d   = isi_cnt_q;
      seen_d      = seen_q;
      isi_d       = isi_q;
      isi_valid_d = 1'b0;
      if (active_i) begin
         if (edge_i) begin
            if (seen_q) begin
               isi_d       = isi_inc;
               isi_valid_d = 1'b1;
            end else begin
               isi_d       = isi_q;
               isi_valid_d = 1'b0;
            end
            isi_cnt_d = '0;
            seen_d    = 1'b1;
         end else begin
            isi_cnt_d = isi_inc;
         end
      end else begin
         isi_cnt_d = '0;
         seen_d    = 1'b0;
      end
   end

   // State registers; the reported interval holds across idle periods.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         isi_cnt_q   <= '0;
         seen_q      <= 1'b0;
         isi_q       <= '0;
         isi_valid_q <= 1'b0;
      end else begin
         isi_cnt_q   <= isi_cnt_d;
         seen_q      <= seen_d;
         isi_q       <= isi_d;
         isi_valid_q <= isi_valid_d;
      end
   end

   assign isi_o       = isi_q;
   assign isi_valid_o = isi_valid_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spike rising edges over back-to-back windows of
// 2^WIN_LOG2 cycles and publishes the count per window, plus the interval
// between consecutive spikes via spike_isi_meter.
// Build option: define SPIKE_DECODE_SMOOTH_EN to publish a running
// round-half-up average of window counts instead of the raw count.
module spike_rate_decoder
   import lif_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = LIF_WIN_LOG2,
   parameter int unsigned CNT_W    = LIF_CNT_W,
   parameter int unsigned ISI_W    = LIF_ISI_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike,
   output logic [CNT_W-1:0] rate_o,
   output logic             rate_valid_o,
   output logic             rate_sat_o,
   output logic [ISI_W-1:0] isi_o,
   output logic             isi_valid_o,
   output logic             active_o
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   lif_state_e          state_q;
   logic                spike_q;
   logic [WIN_LOG2-1:0] win_cnt_q;
   logic [CNT_W-1:0]    spk_cnt_q, spk_cnt_d;
   logic                sat_q, sat_d;
   logic [CNT_W-1:0]    rate_q, rate_d;
   logic                rate_sat_q;
   logic                rate_valid_q;
   logic                spk_edge;
   logic                win_last;
   logic                count_active;
`ifdef SPIKE_DECODE_SMOOTH_EN
   logic                first_q;
   logic [CNT_W:0]      avg_sum;
`endif

   // Edge detect and the closing count/saturation of the current window.
   always_comb begin
      spk_edge     = spike & ~spike_q;
      win_last     = (win_cnt_q == '1);
      count_active = (state_q == ST_COUNT);
      spk_cnt_d    = CNT_W'(sat_inc(32'(spk_cnt_q), CNT_MAX, spk_edge));
      sat_d        = sat_q | (spk_edge & (32'(spk_cnt_q) == CNT_MAX));
   end

`ifdef SPIKE_DECODE_SMOOTH_EN
   // Running average of window counts; the first window after idle loads raw.
   always_comb begin
      avg_sum = {1'b0, rate_q} + {1'b0, spk_cnt_d} + {{CNT_W{1'b0}}, 1'b1};
      if (first_q) begin
         rate_d = spk_cnt_d;
      end else begin
         rate_d = CNT_W'(avg_sum >> 1);
      end
   end
`else
   // Published value is the raw count of the closing window.
   always_comb begin
      rate_d = spk_cnt_d;
   end
`endif

   // Control FSM and window datapath: count edges, close windows, discard on idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         spike_q      <= 1'b0;
         win_cnt_q    <= '0;
         spk_cnt_q    <= '0;
         sat_q        <= 1'b0;
         rate_q       <= '0;
         rate_sat_q   <= 1'b0;
         rate_valid_q <= 1'b0;
`ifdef SPIKE_DECODE_SMOOTH_EN
         first_q      <= 1'b1;
`endif
      end else begin
         spike_q      <= spike;
         rate_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               win_cnt_q <= '0;
               spk_cnt_q <= '0;
               sat_q     <= 1'b0;
`ifdef SPIKE_DECODE_SMOOTH_EN
               first_q   <= 1'b1;
`endif
               if (en) begin
                  state_q <= ST_COUNT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_COUNT: begin
               if (win_last) begin
                  // Closing cycle completes even if en is dropping now.
                  rate_q       <= rate_d;
                  rate_sat_q   <= sat_d;
                  rate_valid_q <= 1'b1;
                  win_cnt_q    <= '0;
                  spk_cnt_q    <= '0;
                  sat_q        <= 1'b0;
`ifdef SPIKE_DECODE_SMOOTH_EN
                  first_q      <= 1'b0;
`endif
               end else if (!en) begin
                  // Partial window is thrown away.
                  win_cnt_q <= '0;
                  spk_cnt_q <= '0;
                  sat_q     <= 1'b0;
               end else begin
                  win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
                  spk_cnt_q <= spk_cnt_d;
                  sat_q     <= sat_d;
               end
               if (en) begin
                  state_q <= ST_COUNT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   spike_isi_meter #(
      .ISI_W (ISI_W)
   ) u_isi (
      .clk         (clk),
      .rst         (rst),
      .edge_i      (spk_edge),
      .active_i    (count_active),
      .isi_o       (isi_o),
      .isi_valid_o (isi_valid_o)
   );

   assign rate_o       = rate_q;
   assign rate_sat_o   = rate_sat_q;
   assign rate_valid_o = rate_valid_q;
   assign active_o     = count_active;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: directed scenarios plus randomized
// enable/spike traffic, checked by a scoreboard against a window/interval
// reference model expressed in absolute cycle numbers.
module tb_spike_rate_decoder;

   localparam int WL   = 4;
   localparam int CW   = 3;
   localparam int IW   = 8;
   localparam int NWIN = 1 << WL;
   localparam int CMAX = (1 << CW) - 1;
   localparam int IMAX = (1 << IW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          spike = 1'b0;
   logic [CW-1:0] rate_o;
   logic          rate_valid_o;
   logic          rate_sat_o;
   logic [IW-1:0] isi_o;
   logic          isi_valid_o;
   logic          active_o;

   always #5 clk = ~clk;

   spike_rate_decoder #(.WIN_LOG2(WL), .CNT_W(CW), .ISI_W(IW)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .spike        (spike),
      .rate_o       (rate_o),
      .rate_valid_o (rate_valid_o),
      .rate_sat_o   (rate_sat_o),
      .isi_o        (isi_o),
      .isi_valid_o  (isi_valid_o),
      .active_o     (active_o)
   );

   typedef struct {
      int   cyc;
      int   val;
      logic sat;
   } exp_t;

   exp_t rate_exp_q[$];
   exp_t isi_exp_q[$];

   // Reference model state (absolute cycle numbers, plain integers)
   int   cyc = 0;
   int   run_len = 0;       // cycles spent active in the current run
   int   win_edges = 0;     // unsaturated edge count in the current window
   int   last_edge = -1;    // cycle of previous edge in this run, -1 = none
   logic en_prev = 1'b0;
   logic spk_prev = 1'b0;
   int   exp_rate = 0;
   logic exp_rsat = 1'b0;
   int   exp_isi = 0;
   logic first_win = 1'b1;

   int checks = 0;
   int passed = 0;

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: advance one clock of the decoder's externally visible behaviour.
   always @(posedge clk or posedge rst) begin
      exp_t e;
      int   edge_now;
      int   cnt;
      if (rst) begin
         run_len   = 0;
         win_edges = 0;
         last_edge = -1;
         en_prev   = 1'b0;
         spk_prev  = 1'b0;
         exp_rate  = 0;
         exp_rsat  = 1'b0;
         exp_isi   = 0;
         first_win = 1'b1;
         rate_exp_q.delete();
         isi_exp_q.delete();
         if (clk) cyc = cyc + 1;
      end else begin
         cyc = cyc + 1;
         edge_now = (spike && !spk_prev) ? 1 : 0;
         if (en_prev) begin
            if (edge_now == 1) begin
               if (last_edge >= 0) begin
                  exp_isi = min_i(cyc - last_edge, IMAX);
                  e.cyc = cyc; e.val = exp_isi; e.sat = 1'b0;
                  isi_exp_q.push_back(e);
               end
               last_edge = cyc;
            end
            win_edges = win_edges + edge_now;
            if ((run_len % NWIN) == NWIN - 1) begin
               cnt      = min_i(win_edges, CMAX);
               exp_rsat = (win_edges > CMAX);
`ifdef SPIKE_DECODE_SMOOTH_EN
               exp_rate = first_win ? cnt : (exp_rate + cnt + 1) / 2;
`else
               exp_rate = cnt;
`endif
               first_win = 1'b0;
               e.cyc = cyc; e.val = exp_rate; e.sat = exp_rsat;
               rate_exp_q.push_back(e);
               win_edges = 0;
            end
            run_len = run_len + 1;
         end else begin
            run_len   = 0;
            win_edges = 0;
            last_edge = -1;
            first_win = 1'b1;
         end
         en_prev  = en;
         spk_prev = spike;
      end
   end

   // Monitor: compare held outputs every cycle and pop scoreboard on valid pulses.
   always @(negedge clk) begin
      exp_t e;
      logic want_rv;
      logic want_iv;
      check("active_o", int'(active_o), int'(en_prev && !rst));
      check("rate_o", int'(rate_o), exp_rate);
      check("rate_sat_o", int'(rate_sat_o), int'(exp_rsat));
      check("isi_o", int'(isi_o), exp_isi);
      want_rv = (rate_exp_q.size() > 0) && (rate_exp_q[0].cyc == cyc);
      check("rate_valid_o", int'(rate_valid_o), int'(want_rv));
      if (want_rv) begin
         e = rate_exp_q.pop_front();
         check("rate_value", int'(rate_o), e.val);
         check("rate_sat_value", int'(rate_sat_o), int'(e.sat));
      end
      want_iv = (isi_exp_q.size() > 0) && (isi_exp_q[0].cyc == cyc);
      check("isi_valid_o", int'(isi_valid_o), int'(want_iv));
      if (want_iv) begin
         e = isi_exp_q.pop_front();
         check("isi_value", int'(isi_o), e.val);
      end
   end

   // Apply inputs for one cycle, starting and ending at a falling edge.
   task automatic step(input logic e, input logic s);
      en    = e;
      spike = s;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rate"}, int'(rate_o), 0);
      check({tag, "_rate_valid"}, int'(rate_valid_o), 0);
      check({tag, "_rate_sat"}, int'(rate_sat_o), 0);
      check({tag, "_isi"}, int'(isi_o), 0);
      check({tag, "_isi_valid"}, int'(isi_valid_o), 0);
      check({tag, "_active"}, int'(active_o), 0);
   endtask

   initial begin
      int p;
      int len;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Spikes at window cycles 0,4,8,15, then an empty window
      step(1'b1, 1'b0);
      for (int i = 0; i < NWIN; i++) step(1'b1, (i == 0 || i == 4 || i == 8 || i == 15));
      for (int i = 0; i < NWIN; i++) step(1'b1, 1'b0);

      // Level already high when enabled never counts; rising at cycle 3 counts once
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      for (int i = 0; i < NWIN + 1; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < NWIN; i++) step(1'b1, (i >= 3));
      step(1'b0, 1'b0);

      // Alternating spike saturates the 3-bit count, then a window with 2 edges
      step(1'b1, 1'b0);
      for (int i = 0; i < NWIN; i++) step(1'b1, i[0]);
      for (int i = 0; i < NWIN; i++) step(1'b1, (i == 2 || i == 9));
      step(1'b0, 1'b0);

      // ISI: edges at COUNT cycles 10 and 17, then 300 apart, then a lone edge
      step(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, (i == 10 || i == 17));
      step(1'b1, 1'b1);
      for (int i = 0; i < 299; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, (i == 5));

      // en dropped at window cycle 9; en dropped exactly on the closing cycle
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, (i % 3 == 0));
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < NWIN - 1; i++) step(1'b1, (i % 4 == 1));
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // Asynchronous reset mid-window with en held high
      step(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, i[0]);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3 * NWIN; i++) step(1'b1, ($urandom_range(0, 3) == 0));

      // Randomized traffic with varying spike density and enable gaps
      for (int seg = 0; seg < 60; seg++) begin
         p   = $urandom_range(0, 100);
         len = $urandom_range(4, 90);
         for (int i = 0; i < len; i++) step(1'b1, ($urandom_range(1, 100) <= p));
         len = $urandom_range(0, 4);
         for (int i = 0; i < len; i++) step(1'b0, ($urandom_range(0, 1) == 1));
      end

      for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
      check("rate_queue_drained", rate_exp_q.size(), 0);
      check("isi_queue_drained", isi_exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive-side counterpart of the LIF neuron: turns a spike train back into numeric values.
- Rate estimate: counts spike rising edges over fixed back-to-back windows and publishes the count per window.
- Also measures the inter-spike interval (ISI) between consecutive spikes.
- Sits downstream of a neuron's spike output (or an off-chip spike pin) and feeds logging/readout logic or the next layer's input current.

Parameters:
- WIN_LOG2, 8, window length = 2^WIN_LOG2 clock cycles (legal 2..16).
- CNT_W, 8, width of spike count and rate_o; count saturates at 2^CNT_W-1.
- ISI_W, 8, width of ISI counter and isi_o; saturates at 2^ISI_W-1.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst  in  1  Reset, asynchronous, active-high.
- en  in  1  Decoder enable; low = IDLE, partial window discarded.
- spike  in  1  Spike level from neuron (same clock domain); rising edge = one spike.
- rate_o  out  CNT_W  Spike count of last completed window (or smoothed value, see option).
- rate_valid_o  out  1  One-cycle pulse: rate_o/rate_sat_o just updated.
- rate_sat_o  out  1  Last completed window's count saturated.
- isi_o  out  ISI_W  Cycles between the last two spike edges (saturating).
- isi_valid_o  out  1  One-cycle pulse: isi_o just updated.
- active_o  out  1  High while in COUNT state.

Behaviour:
- Reset (async, rst=1): every output 0; state IDLE; spike_q=0; all counters 0; ISI "seen" flag 0.
- Edge detect:
  - spike_q registers spike every cycle, including in IDLE.
  - edge = spike & ~spike_q.
  - A level held high counts once; a level already high when en rises never counts.
- FSM, two states:
  - IDLE → COUNT when en=1 (next cycle). Edges during IDLE are ignored.
  - COUNT → IDLE when en=0 (next cycle).
- COUNT window handling:
  - win_cnt (WIN_LOG2 bits) increments every cycle.
  - spk_cnt += edge, saturating at 2^CNT_W-1; a sticky sat flag is set if an edge arrives while spk_cnt is at max.
- Window close (win_cnt all-ones):
  - The edge in this last cycle is included in the closing window.
  - On the closing clock edge: rate_o <= final count, rate_sat_o <= sat flag, rate_valid_o=1 for the next cycle only.
  - spk_cnt, sat flag and win_cnt clear. Windows are back to back with no gap; an edge in the cycle after close counts in the new window.
- en falling mid-window: partial counts discarded, no rate_valid_o. rate_o, rate_sat_o, isi_o hold their last values.
- en falling on the closing cycle: the window completes normally and its rate_valid_o still pulses.
- Re-enable: win_cnt starts at 0 on the first COUNT cycle.
- ISI (COUNT only):
  - isi_cnt increments each cycle, saturating at 2^ISI_W-1.
  - On an edge with seen=1: isi_o <= isi_cnt+1 (saturated), isi_valid_o pulses next cycle.
  - Every edge: isi_cnt <= 0, seen <= 1.
  - First edge after enable only arms; seen and isi_cnt clear on entering IDLE.
  - Edges at t1 < t2 report t2-t1.
- Latency: rate 1 cycle after the window's last cycle; ISI 1 cycle after the second edge.
- rate_valid_o and isi_valid_o are independent and may pulse together.

Optional Feature:
- Macro: SPIKE_DECODE_SMOOTH_EN.
- Defined:
  - rate_o <= (rate_o + count + 1) >> 1, computed at CNT_W+1 bits, round-half-up.
  - The first completed window after enable or reset loads the raw count.
  - rate_sat_o is unaffected.
- Undefined: rate_o = raw window count; no averaging logic synthesized.

Decomposition:
- Shared package lif_pkg:
  - FSM state typedef (ST_IDLE, ST_COUNT).
  - Default constants LIF_WIN_LOG2=8, LIF_CNT_W=8, LIF_ISI_W=8.
  - Saturating-increment function.
- One sub-module, spike_isi_meter: takes edge, active; returns isi_o, isi_valid_o; parameter ISI_W.
- Window/rate logic stays in the top.

Test Plan:
- Reset while en=1 and mid-window (spk_cnt=5): all outputs 0 immediately; after release with en=1, the first rate_valid_o arrives 2^WIN_LOG2 cycles after COUNT entry.
- WIN_LOG2=4, en high, 1-cycle spike pulses at window cycles 0,4,8,15 → rate_o=4, rate_valid_o for exactly 1 cycle after cycle 15; next window with no spikes → rate_o=0.
- spike held high from before en through the whole window → rate_o=0; spike rises at window cycle 3 and stays high → rate_o=1.
- CNT_W=3, WIN_LOG2=4, spike alternating 0/1 each cycle (8 edges) → rate_o=7, rate_sat_o=1; following window with 2 edges → rate_o=2, rate_sat_o=0.
- ISI: edges at COUNT cycles 10 and 17 → isi_o=7, isi_valid_o at cycle 18. ISI_W=8 with edges 300 cycles apart → isi_o=255. A single edge after re-enable → no isi_valid_o.
- en dropped at window cycle 9 → no rate_valid_o, rate_o holds prior value; with SPIKE_DECODE_SMOOTH_EN, consecutive windows counting 8 then 4 → rate_o=8 then 6.
